// File: rtl/alu_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu_if
//  Purpose  : Operand/request/result bundle between the EX stage and the
//             multiply/divide unit. master = requester, slave = alu_mdu.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] iA1;
    logic [WIDTH-1:0] iA2;
    logic             istart;
    logic [2:0]       imdop;
    logic             iabort;
    logic [WIDTH-1:0] ohi;
    logic [WIDTH-1:0] olo;
    logic             obusy;
    logic             odone;
    logic             odivz;

    modport master (
        output iA1, iA2, istart, imdop, iabort,
        input  ohi, olo, obusy, odone, odivz
    );

    modport slave (
        input  iA1, iA2, istart, imdop, iabort,
        output ohi, olo, obusy, odone, odivz
    );
endinterface
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : Multi-cycle signed/unsigned multiply and divide into a HI/LO
//             register pair, plus direct HI/LO writes. Start/busy handshake,
//             abort for exception flush, fixed visible latency per op class.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  wire logic   iclk,
    input  wire logic   irst_n,
    alu_mdu_if.slave    bus
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_OP_DIVU = 3'd3;
    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [1:0]           r_op;        // bit1: divide, bit0: unsigned
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_divz;

    logic                 w_accept;
    logic                 w_start_multi;
    logic                 w_complete;
    logic                 w_divz;

    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_r_mag;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_hi_res;
    logic [WIDTH-1:0]     w_lo_res;

    // State register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept only from IDLE, abort beats completion
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_start_multi = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.istart && !bus.iabort && (bus.imdop <= c_OP_MTLO)) begin
                    w_accept = 1'b1;
                    if (bus.imdop <= c_OP_DIVU) begin
                        w_start_multi = 1'b1;
                        w_state_nxt   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (bus.iabort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result computed from latched operands; one multiplier and one
    // unsigned divider serve both signednesses. Signed division works on
    // magnitudes, so MIN / -1 wraps back to MIN with a zero remainder.
    always_comb begin
        w_a_ext  = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
        w_b_ext  = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
        w_prod   = w_a_ext * w_b_ext;
        w_a_neg  = ~r_op[0] & r_a[WIDTH-1];
        w_b_neg  = ~r_op[0] & r_b[WIDTH-1];
        w_a_mag  = w_a_neg ? -r_a : r_a;
        w_b_mag  = w_b_neg ? -r_b : r_b;
        w_q_mag  = w_a_mag / w_b_mag;
        w_r_mag  = w_a_mag % w_b_mag;
        w_quo    = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
        w_rem    = w_a_neg ? -w_r_mag : w_r_mag;
        w_divz   = r_op[1] & (r_b == '0);
        w_hi_res = r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = r_op[1] ? w_quo : w_prod[WIDTH-1:0];
    end

    // Operand latch, latency counter, HI/LO writes and completion pulses
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_divz <= 1'b0;
        end else begin
            r_done <= w_complete;
            r_divz <= w_complete & w_divz;
            if (w_accept) begin
                if (w_start_multi) begin
                    r_a   <= bus.iA1;
                    r_b   <= bus.iA2;
                    r_op  <= bus.imdop[1:0];
                    r_cnt <= bus.imdop[1] ? c_DIV_CNT : c_MUL_CNT;
                end else if (bus.imdop == c_OP_MTHI) begin
                    r_hi <= bus.iA1;
                end else begin
                    r_lo <= bus.iA1;
                end
            end else if (r_state == S_BUSY) begin
                r_cnt <= bus.iabort ? '0 : (r_cnt - c_CNT_ONE);
                // A zero divisor still spends the full latency but leaves HI/LO alone
                if (w_complete && !w_divz) begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
            end
        end
    end

    assign bus.ohi   = r_hi;
    assign bus.olo   = r_lo;
    assign bus.obusy = (r_state == S_BUSY);
    assign bus.odone = r_done;
    assign bus.odivz = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mdu
//  Purpose  : Randomised scoreboard bench for alu_mdu against a 64-bit
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mdu;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [64:0] exp_q[$];   // {divz, hi, lo}

    alu_mdu_if #(.WIDTH(WIDTH)) bus ();

    alu_mdu #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .iclk   (clk),
        .irst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        logic [64:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            3'd0: begin
                sp  = sa * sb;
                res = {1'b0, sp[63:0]};
            end
            3'd1: begin
                up  = {32'h0, a} * {32'h0, b};
                res = {1'b0, up};
            end
            3'd2: begin
                if (b == 32'h0) res = {1'b1, m_hi, m_lo};
                else begin
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {1'b0, sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {1'b1, m_hi, m_lo};
                else            res = {1'b0, a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Monitor: every odone pops one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.odone) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.odone), 32'h0);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    chk("done_hi",   bus.ohi, e[63:32]);
                    chk("done_lo",   bus.olo, e[31:0]);
                    chk("done_divz", 32'(bus.odivz), 32'(e[64]));
                end
            end else if (bus.odivz) begin
                chk("divz_without_done", 32'(bus.odivz), 32'h0);
            end
        end
    end

    // One request; abort_at/inject_at count busy cycles from 1 (0 = none)
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit idle_abort, input int abort_at,
                         input int inject_at, input logic [2:0] inj_op);
        logic [64:0] e;
        int          lat, n, exp_n;
        bit          acc;
        @(negedge clk);
        bus.istart = 1'b1;
        bus.imdop  = op;
        bus.iA1    = a;
        bus.iA2    = b;
        bus.iabort = idle_abort;
        acc = !idle_abort && (op <= 3'd5);
        lat = op[1] ? DIV_LAT : MUL_LAT;
        if (acc && op <= 3'd3 && abort_at == 0) begin
            e = model(op, a, b);
            exp_q.push_back(e);
            if (!e[64]) begin
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
        @(negedge clk);
        bus.istart = 1'b0;
        bus.iabort = 1'b0;
        bus.iA1    = $urandom;
        bus.iA2    = $urandom;
        bus.imdop  = 3'($urandom);
        if (!acc || op > 3'd3) begin
            if (acc && op == 3'd4) m_hi = a;
            if (acc && op == 3'd5) m_lo = a;
            chk("idle_busy", 32'(bus.obusy), 32'h0);
            chk("idle_hi",   bus.ohi, m_hi);
            chk("idle_lo",   bus.olo, m_lo);
        end else begin
            n = 0;
            while (bus.obusy === 1'b1 && n < 200) begin
                n++;
                bus.iabort = (n == abort_at);
                if (n == inject_at) begin
                    bus.istart = 1'b1;
                    bus.imdop  = inj_op;
                    bus.iA1    = $urandom;
                    bus.iA2    = $urandom;
                end
                @(negedge clk);
                bus.iabort = 1'b0;
                bus.istart = 1'b0;
            end
            exp_n = (abort_at > 0) ? abort_at : lat;
            chk("busy_len", 32'(n), 32'(exp_n));
            if (abort_at > 0 || inject_at > 0) begin
                chk("hold_hi", bus.ohi, m_hi);
                chk("hold_lo", bus.olo, m_lo);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          r, ab;
        bit          ia;

        rst_n      = 1'b0;
        bus.istart = 1'b0;
        bus.imdop  = 3'd0;
        bus.iA1    = '0;
        bus.iA2    = '0;
        bus.iabort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi",   bus.ohi, 32'h0);
        chk("rst_lo",   bus.olo, 32'h0);
        chk("rst_busy", 32'(bus.obusy), 32'h0);
        chk("rst_done", 32'(bus.odone), 32'h0);
        chk("rst_divz", 32'(bus.odivz), 32'h0);
        rst_n = 1'b1;

        // Directed arithmetic cases
        issue(3'd0, 32'hFFFFFFFF, 32'h00000002, 0, 0, 0, 3'd0);
        issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 0, 0, 0, 3'd0);
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002, 0, 0, 0, 3'd0);
        issue(3'd3, 32'h00000007, 32'h00000002, 0, 0, 0, 3'd0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 3'd0);

        // HI/LO preload then divide by zero leaves them unchanged
        issue(3'd4, 32'h00001234, 32'h0, 0, 0, 0, 3'd0);
        issue(3'd5, 32'h00005678, 32'h0, 0, 0, 0, 3'd0);
        issue(3'd2, 32'h0000ABCD, 32'h0, 0, 0, 0, 3'd0);
        issue(3'd3, 32'hDEADBEEF, 32'h0, 0, 0, 0, 3'd0);

        // Requests while busy are dropped; MTLO after busy falls is taken
        issue(3'd0, 32'h00000123, 32'hFFFFFF00, 0, 0, 2, 3'd4);
        issue(3'd0, 32'h00000321, 32'h00000777, 0, 0, 2, 3'd1);
        issue(3'd5, 32'hCAFEF00D, 32'h0, 0, 0, 0, 3'd0);

        // Aborts: mid-divide, same-cycle idle abort, completion-edge abort
        issue(3'd2, 32'h00000064, 32'h00000007, 0, 3, 0, 3'd0);
        issue(3'd0, 32'h00000064, 32'h00000007, 1, 0, 0, 3'd0);
        issue(3'd4, 32'h11111111, 32'h0, 1, 0, 0, 3'd0);
        issue(3'd0, 32'h00000064, 32'h00000007, 0, MUL_LAT, 0, 3'd0);
        issue(3'd3, 32'h00000064, 32'h00000007, 0, DIV_LAT, 0, 3'd0);

        // Reserved opcodes are ignored
        issue(3'd6, 32'h55555555, 32'h1, 0, 0, 0, 3'd0);
        issue(3'd7, 32'hAAAAAAAA, 32'h1, 0, 0, 0, 3'd0);

        // Asynchronous reset in the middle of a multiply
        issue(3'd4, 32'h0BADBEEF, 32'h0, 0, 0, 0, 3'd0);
        @(negedge clk);
        bus.istart = 1'b1;
        bus.imdop  = 3'd0;
        bus.iA1    = 32'd5;
        bus.iA2    = 32'd6;
        @(negedge clk);
        bus.istart = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi",   bus.ohi, 32'h0);
        chk("arst_lo",   bus.olo, 32'h0);
        chk("arst_busy", 32'(bus.obusy), 32'h0);
        chk("arst_done", 32'(bus.odone), 32'h0);
        chk("arst_divz", 32'(bus.odivz), 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 0, 0, 0, 3'd0);
        @(negedge clk);
        chk("post_rst_hi", bus.ohi, 32'h0);
        chk("post_rst_lo", bus.olo, 32'd12);

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0) b = 32'h0;
            else if (r == 1) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end else if (r == 2) b = 32'($urandom_range(1, 15));
            ia = ($urandom_range(0, 9) == 0);
            ab = 0;
            if ($urandom_range(0, 7) == 0)
                ab = int'($urandom_range(1, op[1] ? DIV_LAT : MUL_LAT));
            issue(op, a, b, ia, ab, 0, 3'd0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multiply/divide unit that extends the execute-stage ALU with signed and unsigned multiplication and division into a HI/LO register pair, plus direct HI/LO writes. The unit runs multi-cycle with a start/busy handshake; the pipeline stalls on `obusy`. It sits in the EX stage beside the combinational ALU, shares its operand buses, and feeds HI/LO back for the MFHI/MFLO path.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `MUL_LAT`, 5: busy cycles for MULT/MULTU; ≥1.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU; ≥1.
- `iclk`  in  1: clock, rising edge.
- `irst_n`  in  1: reset, asynchronous, active-low.
- `iA1`  in  WIDTH: operand rs (multiplicand / dividend / MTHI-MTLO data).
- `iA2`  in  WIDTH: operand rt (multiplier / divisor).
- `istart`  in  1: request; sampled each rising edge.
- `imdop`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- `iabort`  in  1: cancel the in-flight operation (exception flush).
- `ohi`  out  WIDTH: HI register.
- `olo`  out  WIDTH: LO register.
- `obusy`  out  1: operation in flight.
- `odone`  out  1: one-cycle pulse; HI/LO just updated by MULT/DIV.
- `odivz`  out  1: one-cycle pulse with `odone`; completed division had a zero divisor.

## Operation
- States: IDLE, BUSY. A down-counter of width clog2(max(MUL_LAT,DIV_LAT)+1) runs in BUSY.
- Accept: rising edge with `istart`=1, `obusy`=0, `iabort`=0, `imdop`≤5.
- Requests while BUSY are ignored and not queued. Reserved opcodes are ignored. `iabort` in IDLE cancels a same-cycle `istart`.
- MTHI/MTLO: write `ohi` or `olo` from `iA1` at the accept edge. Stays IDLE, no `odone`.
- MULT/MULTU/DIV/DIVU:
  - At the accept edge: latch `iA1`, `iA2` and `imdop`, load the counter with the latency, go BUSY.
  - Operand changes after the accept edge have no effect.
- MULT: 2·WIDTH-bit two's-complement product; HI = upper half, LO = lower half.
- MULTU: unsigned product; HI = upper half, LO = lower half.
- DIV:
  - Signed quotient truncates toward zero → LO. Remainder takes the sign of the dividend → HI.
  - MIN / −1: LO = MIN, HI = 0, no flag.
- DIVU: unsigned quotient → LO, remainder → HI.
- Divisor 0 (DIV/DIVU): runs the full DIV_LAT. HI/LO are left unchanged; `odivz` pulses with `odone`.
- Completion: at the edge where the counter reaches 0, write HI/LO, pulse `odone` and return to IDLE.
- Abort: `iabort`=1 in BUSY returns to IDLE at the next edge.
  - HI/LO unchanged, no `odone`.
  - Abort on the completion edge wins: no write.
- Implementation freedom: the result may be computed combinationally from the latched operands or iteratively. Only the visible timing is specified.

## Timing
- Reset (`irst_n`=0, asynchronous): IDLE, counter 0, `ohi`=0, `olo`=0, `obusy`=0, `odone`=0, `odivz`=0. Reset mid-operation discards the operation.
- Accept edge k (multi-cycle op):
  - `obusy` is high after edge k through edge k+LAT.
  - At edge k+LAT: HI/LO update, `obusy` falls, `odone` (and `odivz` if applicable) are high for the cycle after k+LAT.
- Back-to-back: a new `istart` is accepted at edge k+LAT+1 at the earliest, because the request is sampled while `obusy` is still high before edge k+LAT.
- MTHI/MTLO: `ohi`/`olo` show the new value in the cycle after the accept edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Defaults: WIDTH=32, MUL_LAT=5, DIV_LAT=10.
- MULT 0xFFFFFFFF×0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after exactly 5 busy cycles, `odone` 1 cycle. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1 after 10 busy cycles. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x1234, LO=0x5678 via MTHI/MTLO, then DIV x/0 → HI/LO unchanged; `odivz` and `odone` pulse together at cycle 10.
- During MULT: MTHI and MULTU requests in busy cycle 2 → ignored; HI/LO hold the MULT result. MTLO issued after `obusy` falls → written.
- `iabort` in busy cycle 3 of DIV → IDLE next edge, HI/LO unchanged, no `odone`. `iabort`+`istart` in IDLE → no accept. Abort on the completion edge → no write.
- `irst_n` pulsed low mid-MULT (asynchronous, between edges) → all outputs 0 immediately. A fresh MULT 3×4 after release → LO=12, HI=0.
